// File: rtl/tff_bank_ctrl_if.sv
// Command/status bundle for tff_bank_ctrl.
// Optional abort input present only when TFF_CTRL_ABORT_EN is defined.
interface tff_bank_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] tog;
  logic             busy;
  logic             done;
`ifdef TFF_CTRL_ABORT_EN
  logic             abort;

  modport master (
    output cmd_valid, cmd_op, cmd_data, abort,
    input  cmd_ready, q, tog, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, abort,
    output cmd_ready, q, tog, busy, done
  );
`else
  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, q, tog, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, q, tog, busy, done
  );
`endif
endinterface

// File: rtl/tff_bank_ctrl.sv
// Bank of WIDTH toggle flip-flops driven by a small command FSM.
// A command fixes a toggle mask; up to LANES mask bits are toggled per clock.
// Optional feature: define TFF_CTRL_ABORT_EN to add an abort input that ends RUN early.
// The interface instance must be built with the same WIDTH as this module.
module tff_bank_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 2
) (
  input  logic            clk,
  input  logic            reset,
  tff_bank_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [1:0] OpLoad  = 2'b00;
  localparam logic [1:0] OpInc   = 2'b01;
  localparam logic [1:0] OpClear = 2'b10;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] tog;
  logic [WIDTH-1:0] mask;
  logic             abort_w;

`ifdef TFF_CTRL_ABORT_EN
  assign abort_w = bus.abort;
`else
  assign abort_w = 1'b0;
`endif

  // Toggle mask: lowest LANES set bits of the remaining mask, only in RUN and not on abort.
  always_comb begin
    int unsigned lanes_used;
    tog        = '0;
    lanes_used = 0;
    if (state_q == StRun && !abort_w) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (rem_q[i] && lanes_used < LANES) begin
          tog[i]     = 1'b1;
          lanes_used = lanes_used + 1;
        end
      end
    end
  end

  // Next state, bank and remaining-mask update.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    rem_d   = rem_q;
    mask    = '0;
    case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          case (bus.cmd_op)
            OpLoad:  mask = q_q ^ bus.cmd_data;
            OpInc:   mask = q_q ^ (q_q + WIDTH'(1));
            OpClear: mask = q_q;
            default: mask = '1;
          endcase
          rem_d   = mask;
          state_d = (mask != '0) ? StRun : StDone;
        end
      end
      StRun: begin
        if (abort_w) begin
          rem_d   = '0;
          state_d = StDone;
        end else begin
          q_d   = q_q ^ tog;
          rem_d = rem_q & ~tog;
          if (rem_d == '0) begin
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      q_q     <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
    end
  end

  assign bus.q         = q_q;
  assign bus.tog       = tog;
  assign bus.cmd_ready = (state_q == StIdle);
  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = (state_q == StDone);

endmodule

// File: tb/tb_tff_bank_ctrl.sv
// Scoreboard bench for tff_bank_ctrl (WIDTH=8, LANES=2).
module tb_tff_bank_ctrl;
  localparam int unsigned Width = 8;
  localparam int unsigned Lanes = 2;

  logic clk;
  logic reset;

  tff_bank_ctrl_if #(.WIDTH(Width)) bus ();

  tff_bank_ctrl #(.WIDTH(Width), .LANES(Lanes)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  int unsigned done_cnt = 0;
  logic [7:0]  exp_tog_q[$];
  logic [7:0]  exp_q_q[$];
  logic [7:0]  model_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: peel lowest set bits of the mask, Lanes per cycle.
  task automatic push_model(input logic [1:0] op, input logic [7:0] data);
    logic [7:0] m, r, t, lb;
    case (op)
      2'b00:   m = model_q ^ data;
      2'b01:   m = model_q ^ (model_q + 8'd1);
      2'b10:   m = model_q;
      default: m = 8'hFF;
    endcase
    r = m;
    while (r != 8'h00) begin
      t = 8'h00;
      for (int k = 0; k < int'(Lanes); k++) begin
        if (r != 8'h00) begin
          lb = r & (~r + 8'd1);
          t  = t | lb;
          r  = r & ~lb;
        end
      end
      exp_tog_q.push_back(t);
    end
    model_q = model_q ^ m;
    exp_q_q.push_back(model_q);
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!reset) begin
      check("ready_vs_busy", bus.cmd_ready, !bus.busy);
      if (!bus.busy) check("idle_tog", bus.tog, 0);
      if (bus.busy && !bus.done) begin
        if (exp_tog_q.size() == 0) begin
          check("run_extra", exp_tog_q.size(), 1);
        end else begin
          e = exp_tog_q.pop_front();
          check("tog", bus.tog, e);
        end
      end
      if (bus.done) begin
        done_cnt++;
        check("done_tog", bus.tog, 0);
        check("run_len", exp_tog_q.size(), 0);
        exp_tog_q.delete();
        if (exp_q_q.size() == 0) begin
          check("done_unexp", exp_q_q.size(), 1);
        end else begin
          e = exp_q_q.pop_front();
          check("q_final", bus.q, e);
        end
      end
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 50 && !bus.cmd_ready; i++) begin
      @(posedge clk);
      #1;
    end
    if (!bus.cmd_ready) check("ready_timeout", bus.cmd_ready, 1);
  endtask

  // Present one command; returns 1 time unit after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [7:0] data);
    wait_ready();
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int unsigned start);
    for (int i = 0; i < 50 && done_cnt == start; i++) begin
      @(posedge clk);
      #1;
    end
    if (done_cnt == start) check("done_timeout", done_cnt, start + 1);
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] data, input bit use_model);
    int unsigned start;
    if (use_model) push_model(op, data);
    start = done_cnt;
    issue(op, data);
    wait_done(start);
  endtask

  initial begin
    int unsigned start;
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_data  = 8'h00;
`ifdef TFF_CTRL_ABORT_EN
    bus.abort     = 1'b0;
`endif
    model_q = 8'h00;
    #2;
    check("rst_q", bus.q, 8'h00);
    check("rst_ready", bus.cmd_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    #10;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // LOAD 0xA5 from 0x00
    exp_tog_q.push_back(8'h05);
    exp_tog_q.push_back(8'hA0);
    exp_q_q.push_back(8'hA5);
    model_q = 8'hA5;
    send(2'b00, 8'hA5, 1'b0);

    // INC from 0xFF wraps to 0x00
    send(2'b00, 8'hFF, 1'b1);
    exp_tog_q.push_back(8'h03);
    exp_tog_q.push_back(8'h0C);
    exp_tog_q.push_back(8'h30);
    exp_tog_q.push_back(8'hC0);
    exp_q_q.push_back(8'h00);
    model_q = 8'h00;
    send(2'b01, 8'h00, 1'b0);

    // LOAD of the current value skips RUN
    send(2'b00, 8'h3C, 1'b1);
    exp_q_q.push_back(8'h3C);
    start = done_cnt;
    issue(2'b00, 8'h3C);
    check("skip_run_done", bus.done, 1);
    wait_done(start);

    // INVERT from 0x00, reset after the second RUN edge
    send(2'b10, 8'h00, 1'b1);
    exp_tog_q.push_back(8'h03);
    exp_tog_q.push_back(8'h0C);
    exp_tog_q.push_back(8'h30);
    exp_tog_q.push_back(8'hC0);
    exp_q_q.push_back(8'hFF);
    issue(2'b11, 8'h00);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("inv_partial_q", bus.q, 8'h0F);
    start = done_cnt;
    reset = 1'b1;
    #1;
    check("midrst_q", bus.q, 8'h00);
    check("midrst_ready", bus.cmd_ready, 1);
    check("midrst_busy", bus.busy, 0);
    exp_tog_q.delete();
    exp_q_q.delete();
    model_q = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("no_done_after_rst", done_cnt, start);
    send(2'b00, 8'h5A, 1'b1);

    // cmd_valid during RUN is ignored
    push_model(2'b00, 8'hF0);
    start = done_cnt;
    issue(2'b00, 8'hF0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b11;
    bus.cmd_data  = 8'h00;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    wait_done(start);

    for (int n = 0; n < 6; n++) begin
      send(2'($urandom_range(0, 3)), 8'($urandom), 1'b1);
    end

`ifdef TFF_CTRL_ABORT_EN
    send(2'b00, 8'hFF, 1'b1);
    exp_tog_q.push_back(8'h03);
    exp_tog_q.push_back(8'h00);
    exp_q_q.push_back(8'hFC);
    model_q = 8'hFC;
    start = done_cnt;
    issue(2'b10, 8'h00);
    @(posedge clk);
    #1;
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    wait_done(start);
`endif

    repeat (2) @(posedge clk);
    #1;
    check("sb_tog_left", exp_tog_q.size(), 0);
    check("sb_q_left", exp_q_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tff_bank_ctrl.md
TFF_BANK_CTRL -- requirements
Module: tff_bank_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, number of toggle flip-flops in the bank.
REQ-002 Parameter LANES, default 2, maximum number of bank bits toggled per clock (1..WIDTH).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  controller can accept a command.
REQ-007 cmd_op  input  2  00 LOAD, 01 INC, 10 CLEAR, 11 INVERT.
REQ-008 cmd_data  input  WIDTH  LOAD target; ignored for other ops.
REQ-009 q  output  WIDTH  bank state, one T flip-flop per bit.
REQ-010 tog  output  WIDTH  toggle mask applied at the coming edge.
REQ-011 busy  output  1  high while in RUN or DONE.
REQ-012 done  output  1  single-cycle completion pulse.

Function
REQ-013 Each bank bit SHALL behave as a T flip-flop: q[i] <= ~q[i] when tog[i]=1, else hold.
REQ-014 The FSM SHALL have states IDLE, RUN and DONE; cmd_ready SHALL equal (state==IDLE).
REQ-015 A command SHALL be accepted on a rising edge with cmd_valid && cmd_ready; cmd_op/cmd_data SHALL be sampled only then.
REQ-016 On accept, the remaining mask rem SHALL be loaded: LOAD q^cmd_data, INC q^(q+1) mod 2^WIDTH, CLEAR q, INVERT all ones.
REQ-017 On accept, the next state SHALL be RUN if the new rem != 0, else DONE.
REQ-018 In RUN, tog SHALL equal the lowest min(LANES, popcount(rem)) set bits of rem; at the edge, q ^= tog and rem &= ~tog.
REQ-019 RUN SHALL go to DONE on the edge at which rem becomes 0; RUN therefore lasts ceil(popcount(mask)/LANES) cycles.
REQ-020 tog SHALL be 0 in IDLE and DONE.
REQ-021 In DONE, done SHALL be 1 for exactly one cycle, followed by an unconditional return to IDLE.
REQ-022 INC from all ones SHALL wrap to 0; no carry or overflow flag.
REQ-023 cmd_valid while busy SHALL be ignored, with no queuing.

Reset
REQ-024 Reset SHALL force, immediately and regardless of clk: state IDLE, q=0, rem=0, tog=0, done=0, busy=0, cmd_ready=1.
REQ-025 Reset during RUN SHALL discard the remaining toggles; no done pulse SHALL follow.

Configuration
REQ-026 With TFF_CTRL_ABORT_EN defined, an input abort (1 bit) SHALL exist; abort=1 in RUN SHALL clear rem, apply no toggle that cycle (tog=0), and go to DONE, so that the done pulse still occurs.
REQ-027 Without TFF_CTRL_ABORT_EN, the abort port SHALL be absent and RUN SHALL always complete.

Verification (WIDTH=8, LANES=2)
REQ-028 Reset asserted mid-cycle -> q=0x00, cmd_ready=1, busy=0 without a clock edge.
REQ-029 From q=0x00, LOAD 0xA5 -> 2 RUN cycles with tog=0x05 then 0xA0, q=0xA5, then a done pulse and cmd_ready=1.
REQ-030 From q=0xFF, INC -> 4 RUN cycles with tog 0x03, 0x0C, 0x30, 0xC0; q=0x00 (wrap); done pulses.
REQ-031 From q=0x3C, LOAD 0x3C -> RUN skipped; done is high in the cycle after accept; q is unchanged.
REQ-032 From q=0x00, INVERT with reset asserted after the 2nd RUN edge (q=0x0F) -> q=0x00, no done pulse, and a new command is accepted afterwards.
REQ-033 With TFF_CTRL_ABORT_EN defined, from q=0x00, CLEAR after LOAD 0xFF (q=0xFF), abort in the 2nd RUN cycle -> q=0xFC, done pulses.
